// File: rtl/fp32_add_pipe.sv
// fp32_add_pipe: IEEE-754 binary32 adder, RNE, input register + 3 stages (unpack/align, add, normalise/round).
// Optional macro FP32_ADD_SUB_EN adds port 'sub' selecting a - b.
module fp32_add_pipe #(
   parameter bit FTZ = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
`ifdef FP32_ADD_SUB_EN
   input  logic        sub,
`endif
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum,
   output logic        valid_out
);
   localparam int          STAGES = 3;
   localparam logic [31:0] QNAN   = 32'h7FC0_0000;

   function automatic logic [7:0] lzc27(input logic [26:0] v);
      lzc27 = 8'd27;
      for (int i = 0; i <= 26; i++)
         if (v[i]) lzc27 = 8'(26 - i);
   endfunction

   logic sub_en;
`ifdef FP32_ADD_SUB_EN
   assign sub_en = sub;
`else
   assign sub_en = 1'b0;
`endif

   logic [STAGES:0] vld_pipe_q;
   logic [31:0]     a_q, b_q, sum_q;

   // S1 registers
   logic        s1_sx_q, s1_sub_q, s1_spec_q, s1_zsign_q;
   logic [7:0]  s1_ex_q;
   logic [23:0] s1_mx_q;
   logic [26:0] s1_my_q;
   logic [31:0] s1_spec_val_q;
   // S2 registers
   logic        s2_sx_q, s2_spec_q, s2_zsign_q;
   logic [7:0]  s2_ex_q;
   logic [27:0] s2_mag_q;
   logic [31:0] s2_spec_val_q;

   // ---------------- S1: classify, order by magnitude, align ----------------
   logic        a_nan, b_nan, a_inf, b_inf, swap;
   logic [30:0] ma, mb, mx, my;
   logic [7:0]  ex, ey, dexp;
   logic [4:0]  dsh;
   logic [23:0] sig_y;
   logic [53:0] y_wide;
   logic        s1_sx_d, s1_sub_d, s1_spec_d, s1_zsign_d;
   logic [7:0]  s1_ex_d;
   logic [23:0] s1_mx_d;
   logic [26:0] s1_my_d;
   logic [31:0] s1_spec_val_d;

   always_comb begin
      a_nan = (&a_q[30:23]) & (|a_q[22:0]);
      b_nan = (&b_q[30:23]) & (|b_q[22:0]);
      a_inf = (&a_q[30:23]) & ~(|a_q[22:0]);
      b_inf = (&b_q[30:23]) & ~(|b_q[22:0]);
      ma    = (FTZ && a_q[30:23] == 8'd0) ? 31'd0 : a_q[30:0];
      mb    = (FTZ && b_q[30:23] == 8'd0) ? 31'd0 : b_q[30:0];
      // {exp,frac} compares as an unsigned magnitude
      swap  = mb > ma;
      mx    = swap ? mb : ma;
      my    = swap ? ma : mb;
      ex    = (mx[30:23] == 8'd0) ? 8'd1 : mx[30:23];
      ey    = (my[30:23] == 8'd0) ? 8'd1 : my[30:23];
      dexp  = ex - ey;
      dsh   = (dexp > 8'd27) ? 5'd27 : dexp[4:0];
      sig_y = {my[30:23] != 8'd0, my[22:0]};
      // window is y_wide[53:27]; everything below collapses into sticky
      y_wide = {sig_y, 30'd0} >> dsh;

      s1_sx_d    = swap ? b_q[31] : a_q[31];
      s1_sub_d   = a_q[31] ^ b_q[31];
      s1_zsign_d = a_q[31] & b_q[31];
      s1_ex_d    = ex;
      s1_mx_d    = {mx[30:23] != 8'd0, mx[22:0]};
      s1_my_d    = {y_wide[53:28], y_wide[27] | (|y_wide[26:0])};
      s1_spec_d  = a_nan | b_nan | a_inf | b_inf;
      if (a_nan || b_nan || (a_inf && b_inf && (a_q[31] ^ b_q[31])))
         s1_spec_val_d = QNAN;
      else if (a_inf)
         s1_spec_val_d = {a_q[31], 8'hFF, 23'd0};
      else
         s1_spec_val_d = {b_q[31], 8'hFF, 23'd0};
   end

   // ---------------- S2: magnitude add/sub (|X| >= |Y| so never negative) ---
   logic [27:0] s2_mag_d;
   assign s2_mag_d = s1_sub_q ? ({1'b0, s1_mx_q, 3'b000} - {1'b0, s1_my_q})
                              : ({1'b0, s1_mx_q, 3'b000} + {1'b0, s1_my_q});

   // ---------------- S3: normalise, round, pack ------------------------------
   logic [7:0]  lz, sh;
   logic        tiny, rnd_up, ovf;
   logic [26:0] m27;
   logic [8:0]  e9, e_fld;
   logic [31:0] rnd, res_d;

   always_comb begin
      lz   = lzc27(s2_mag_q[26:0]);
      tiny = 1'b0;
      sh   = 8'd0;
      if (s2_mag_q[27]) begin
         m27 = {s2_mag_q[27:2], s2_mag_q[1] | s2_mag_q[0]};
         e9  = {1'b0, s2_ex_q} + 9'd1;
      end else begin
         // left shift stops at exponent 1; anything left unnormalised is subnormal
         tiny = lz > (s2_ex_q - 8'd1);
         sh   = tiny ? (s2_ex_q - 8'd1) : lz;
         m27  = s2_mag_q[26:0] << sh;
         e9   = {1'b0, s2_ex_q} - {1'b0, sh};
      end
      e_fld  = m27[26] ? e9 : 9'd0;
      rnd_up = m27[2] & (m27[3] | m27[1] | m27[0]);
      // rounding carry ripples from the fraction straight into the exponent field
      rnd    = {e_fld, m27[25:3]} + {31'd0, rnd_up};
      ovf    = rnd[31:23] >= 9'd255;

      if (s2_spec_q)             res_d = s2_spec_val_q;
      else if (s2_mag_q == '0)   res_d = {s2_zsign_q, 31'd0};
      else if (FTZ && tiny)      res_d = {s2_sx_q, 31'd0};
      else if (ovf)              res_d = {s2_sx_q, 8'hFF, 23'd0};
      else                       res_d = {s2_sx_q, rnd[30:0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe_q    <= '0;
         a_q           <= '0;
         b_q           <= '0;
         s1_sx_q       <= 1'b0;
         s1_sub_q      <= 1'b0;
         s1_spec_q     <= 1'b0;
         s1_zsign_q    <= 1'b0;
         s1_ex_q       <= '0;
         s1_mx_q       <= '0;
         s1_my_q       <= '0;
         s1_spec_val_q <= '0;
         s2_sx_q       <= 1'b0;
         s2_spec_q     <= 1'b0;
         s2_zsign_q    <= 1'b0;
         s2_ex_q       <= '0;
         s2_mag_q      <= '0;
         s2_spec_val_q <= '0;
         sum_q         <= '0;
      end else begin
         vld_pipe_q    <= {vld_pipe_q[STAGES-1:0], valid_in};
         a_q           <= a;
         b_q           <= {b[31] ^ sub_en, b[30:0]};
         s1_sx_q       <= s1_sx_d;
         s1_sub_q      <= s1_sub_d;
         s1_spec_q     <= s1_spec_d;
         s1_zsign_q    <= s1_zsign_d;
         s1_ex_q       <= s1_ex_d;
         s1_mx_q       <= s1_mx_d;
         s1_my_q       <= s1_my_d;
         s1_spec_val_q <= s1_spec_val_d;
         s2_sx_q       <= s1_sx_q;
         s2_spec_q     <= s1_spec_q;
         s2_zsign_q    <= s1_zsign_q;
         s2_ex_q       <= s1_ex_q;
         s2_mag_q      <= s2_mag_d;
         s2_spec_val_q <= s1_spec_val_q;
         if (vld_pipe_q[STAGES-1]) sum_q <= res_d;
      end
   end

   assign valid_out = vld_pipe_q[STAGES];
   assign sum       = sum_q;

endmodule

// File: tb/tb_fp32_add_pipe.sv
// Bench for fp32_add_pipe: FTZ=1 and FTZ=0 instances side by side against a real-arithmetic model.
module tb_fp32_add_pipe;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_in = 1'b0;
   logic [31:0] a = '0, b = '0;
`ifdef FP32_ADD_SUB_EN
   logic        sub = 1'b0;
`endif
   logic [31:0] sum1, sum0;
   logic        vo1, vo0;

   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   fp32_add_pipe #(.FTZ(1'b1)) u_ftz (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
`ifdef FP32_ADD_SUB_EN
      .sub(sub),
`endif
      .a(a), .b(b), .sum(sum1), .valid_out(vo1));

   fp32_add_pipe #(.FTZ(1'b0)) u_full (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
`ifdef FP32_ADD_SUB_EN
      .sub(sub),
`endif
      .a(a), .b(b), .sum(sum0), .valid_out(vo0));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_chk++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, expv, $time);
      end
   endtask

   function automatic real fp_val(input logic [31:0] x, input bit ftz);
      real m;
      int  e;
      if (x[30:23] == 8'd0) begin
         if (ftz) return 0.0;
         m = real'(x[22:0]);
         e = 1;
      end else begin
         m = real'({1'b1, x[22:0]});
         e = int'(x[30:23]);
      end
      m = m * (2.0 ** (e - 150));
      return x[31] ? -m : m;
   endfunction

   // Exact real sum, then RNE to binary32 with the FTZ/overflow rules.
   function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y, input bit ftz);
      bit     xn, yn, xi, yi, neg;
      real    s, mag, q;
      int     e2, qi;
      longint bits;
      xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
      yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
      xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
      yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
      if (xn || yn) return 32'h7FC00000;
      if (xi && yi) return (x[31] != y[31]) ? 32'h7FC00000 : x;
      if (xi) return x;
      if (yi) return y;
      s = fp_val(x, ftz) + fp_val(y, ftz);
      if (s == 0.0) return {x[31] & y[31], 31'd0};
      neg = s < 0.0;
      mag = neg ? -s : s;
      e2 = -150;
      for (int k = -149; k <= 128; k++)
         if (mag >= 2.0 ** k) e2 = k;
      if (e2 < -126) begin
         if (ftz) return {neg, 31'd0};
         q = mag * (2.0 ** 149);
      end else begin
         q = mag / (2.0 ** (e2 - 23));
      end
      qi = $rtoi(q);
      if ((q - qi) > 0.5 || ((q - qi) == 0.5 && qi[0])) qi++;
      if (e2 < -126) bits = longint'(qi);
      else           bits = (longint'(e2 + 127) <<< 23) + longint'(qi) - (longint'(1) <<< 23);
      if (bits >= (longint'(255) <<< 23)) return {neg, 8'hFF, 23'd0};
      return {neg, bits[30:0]};
   endfunction

   // hist[k] = operation sampled k edges ago; hist[3] is due at the output now
   bit          hv [4];
   logic [31:0] h1 [4];
   logic [31:0] h0 [4];
   logic [31:0] exp1 = '0, exp0 = '0;

   task automatic issue(input bit v, input logic [31:0] x, input logic [31:0] y, input bit s);
      logic [31:0] yy;
      valid_in = v;
      a = x;
      b = y;
`ifdef FP32_ADD_SUB_EN
      sub = s;
`endif
      yy = {y[31] ^ s, y[30:0]};
      @(posedge clk);
      for (int i = 3; i > 0; i--) begin
         hv[i] = hv[i-1];
         h1[i] = h1[i-1];
         h0[i] = h0[i-1];
      end
      hv[0] = v;
      h1[0] = ref_add(x, yy, 1'b1);
      h0[0] = ref_add(x, yy, 1'b0);
      @(negedge clk);
      if (hv[3]) begin
         exp1 = h1[3];
         exp0 = h0[3];
      end
      chk("vo_ftz", {31'd0, vo1}, {31'd0, hv[3]});
      chk("sum_ftz", sum1, exp1);
      chk("vo_full", {31'd0, vo0}, {31'd0, hv[3]});
      chk("sum_full", sum0, exp0);
   endtask

   localparam int ND = 14;
   localparam logic [31:0] DA [ND] = '{
      32'h3F800000, 32'h3F8CCCCD, 32'h80000000, 32'h7F800000, 32'h7F7FFFFF,
      32'h7FC12345, 32'h00000001, 32'h3F800000, 32'h80000000, 32'hFF800000,
      32'h00800000, 32'h00800001, 32'h3F800000, 32'hC0000000};
   localparam logic [31:0] DB [ND] = '{
      32'h3F8CCCCD, 32'hBF8CCCCD, 32'h80000000, 32'hFF800000, 32'h7F7FFFFF,
      32'h3F800000, 32'h00000001, 32'h33800000, 32'h00000000, 32'h7F7FFFFF,
      32'h80000001, 32'h80800000, 32'h00000001, 32'h3F800000};
   localparam logic [31:0] SA [4] = '{32'h3F800000, 32'h40400000, 32'hC1200000, 32'h3DCCCCCD};
   localparam logic [31:0] SB [4] = '{32'h3F800000, 32'hBF000000, 32'h40A00000, 32'h3E4CCCCD};

   initial begin
      logic [31:0] rx, ry, tmp;
      int          rey;
      bit          vv, ss;
      for (int i = 0; i < 4; i++) begin
         hv[i] = 1'b0; h1[i] = '0; h0[i] = '0;
      end

      #12;
      chk("rst_vo_ftz", {31'd0, vo1}, 32'd0);
      chk("rst_sum_ftz", sum1, 32'd0);
      chk("rst_vo_full", {31'd0, vo0}, 32'd0);
      chk("rst_sum_full", sum0, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) issue(1'b0, '0, '0, 1'b0);

      // isolated pulses: one output cycle each, sum held in between
      for (int i = 0; i < ND; i++) begin
         issue(1'b1, DA[i], DB[i], 1'b0);
         repeat (4) issue(1'b0, '0, '0, 1'b0);
      end
`ifdef FP32_ADD_SUB_EN
      issue(1'b1, 32'h7F800000, 32'h7F800000, 1'b1);
      issue(1'b1, 32'h40000000, 32'h3F800000, 1'b1);
      repeat (4) issue(1'b0, '0, '0, 1'b0);
`endif

      // back-to-back stream
      for (int i = 0; i < 4; i++) issue(1'b1, SA[i], SB[i], 1'b0);
      repeat (5) issue(1'b0, '0, '0, 1'b0);

      // same stream, reset asserted after the third issue
      for (int i = 0; i < 3; i++) issue(1'b1, SA[i], SB[i], 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_vo_ftz", {31'd0, vo1}, 32'd0);
      chk("midrst_sum_ftz", sum1, 32'd0);
      chk("midrst_vo_full", {31'd0, vo0}, 32'd0);
      chk("midrst_sum_full", sum0, 32'd0);
      for (int i = 0; i < 4; i++) hv[i] = 1'b0;
      exp1 = '0;
      exp0 = '0;
      valid_in = 1'b1;
      a = SA[3];
      b = SB[3];
      @(posedge clk);
      @(negedge clk);
      valid_in = 1'b0;
      rst_n = 1'b1;
      repeat (6) issue(1'b0, '0, '0, 1'b0);

      // random traffic with exponents kept within 28 of each other
      for (int n = 0; n < 400; n++) begin
         rx = $urandom;
         case ($urandom_range(11))
            0: rx[30:23] = 8'h00;
            1: begin
               rx[30:23] = 8'hFF;
               if ($urandom_range(1) == 0) rx[22:0] = '0;
            end
            2: rx[30:23] = 8'hFE;
            3: rx[30:23] = 8'h01;
            default: if (rx[30:23] == 8'hFF) rx[30:23] = 8'h80;
         endcase
         ry  = $urandom;
         rey = int'(rx[30:23]) + int'($urandom_range(56)) - 28;
         if (rey < 0)   rey = 0;
         if (rey > 254) rey = 254;
         ry[30:23] = 8'(rey);
         case ($urandom_range(7))
            0: ry = {~rx[31], rx[30:0]};
            1: ry = {~rx[31], rx[30:1], ~rx[0]};
            default: ;
         endcase
         if ($urandom_range(1) == 1) begin
            tmp = rx; rx = ry; ry = tmp;
         end
         vv = ($urandom_range(3) != 0);
`ifdef FP32_ADD_SUB_EN
         ss = ($urandom_range(1) == 1);
`else
         ss = 1'b0;
`endif
         issue(vv, rx, ry, ss);
      end
      repeat (4) issue(1'b0, '0, '0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
